// File: rtl/wb_deserializer.sv
// wb_deserializer: receive end of the serial link. It recovers 27-bit
// frames (start 0, 27 data bits MSB first, stop 1) from a one-bit line,
// queues them in a small FIFO and exposes them through a Wishbone slave.
module wb_deserializer #(
  parameter int         WORD_W     = 9,
  parameter int         N_WORDS    = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] ADR_DATA   = 2'd0,
  parameter logic [1:0] ADR_STATUS = 2'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_i,
  output logic        rx_valid_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O
);

  localparam int FRAME_W = WORD_W * N_WORDS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int CW      = $clog2(FRAME_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic               sync_d, sync_q;
  logic [1:0]         state;
  logic [CW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wptr, rptr, level;
  logic               empty, full;
  logic               push, pop, wr_en;
  logic               ovr_set, ferr_set, clr_ovr, clr_ferr;
  logic               overrun_q, frame_err_q;
  logic               req;
  logic [3:0]         level4;
  logic               unused_ok;

  assign unused_ok = ^{ADR_I[31:2], DAT_I[31:3], DAT_I[0]};

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_d <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync_d <= data_i;
      sync_q <= sync_d;
    end
  end

  // Frame receiver FSM: start detect, 27-bit shift, stop check.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: if (!sync_q) begin
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg <= {shreg[FRAME_W-2:0], sync_q};
          if (bit_cnt == LAST_BIT) state <= S_STOP;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        S_STOP: state <= sync_q ? S_IDLE : S_WAIT;
        default: if (sync_q) state <= S_IDLE;
      endcase
    end
  end

  assign push     = (state == S_STOP) && sync_q;
  assign ferr_set = (state == S_STOP) && !sync_q;
  assign level    = wptr - rptr;
  assign empty    = (level == '0);
  assign full     = (level == PW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign level4   = 4'(level);
  assign req      = CYC_I && STB_I;
  assign rx_valid_o = !empty;

  // Frame storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr[AW-1:0]] <= shreg;
  end

  // FIFO pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

  // Sticky flags, write-1-to-clear; a same-cycle set beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ovr_set  || (overrun_q   && !clr_ovr);
      frame_err_q <= ferr_set || (frame_err_q && !clr_ferr);
    end
  end

  // Combinational Wishbone decode; ACK/ERR answer in the request cycle.
  always_comb begin
    ACK_O    = 1'b0;
    ERR_O    = 1'b0;
    DAT_O    = '0;
    pop      = 1'b0;
    clr_ovr  = 1'b0;
    clr_ferr = 1'b0;
    if (req) begin
      if (ADR_I[1:0] == ADR_DATA && !WE_I) begin
        if (!empty) begin
          ACK_O = 1'b1;
          DAT_O = 32'(mem[rptr[AW-1:0]]);
          pop   = 1'b1;
        end else begin
          ERR_O = 1'b1;
        end
      end else if (ADR_I[1:0] == ADR_STATUS) begin
        ACK_O = 1'b1;
        if (WE_I) begin
          clr_ovr  = DAT_I[2];
          clr_ferr = DAT_I[1];
        end else begin
          DAT_O = {24'b0, level4, 1'b0, overrun_q, frame_err_q, empty};
        end
      end else begin
        ERR_O = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_deserializer.sv
// Scoreboard bench for wb_deserializer: frames are queued when sent and
// compared when read back over Wishbone.
module tb_wb_deserializer;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0, rst_ni = 1'b0, data_i = 1'b1;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0;
  logic        rx_valid_o, ACK_O, ERR_O;
  logic [31:0] DAT_O;

  int          n_chk = 0, n_err = 0;
  logic [26:0] sbq[$];
  logic        exp_ovr = 1'b0, exp_ferr = 1'b0;

  wb_deserializer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .rx_valid_o(rx_valid_o),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .DAT_O(DAT_O)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Start bit, 27 bits MSB first, stop bit; line left high afterwards.
  task automatic send_frame(input logic [26:0] f, input logic stop);
    data_i = 1'b0; tick();
    for (int i = 26; i >= 0; i--) begin
      data_i = f[i]; tick();
    end
    data_i = stop; tick();
    data_i = 1'b1;
  endtask

  task automatic sb_push(input logic [26:0] f);
    if (sbq.size() < DEPTH) sbq.push_back(f);
    else exp_ovr = 1'b1;
  endtask

  task automatic wb_cycle(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic ack, output logic err);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = {30'b0, adr}; DAT_I = wdat;
    #1;
    rdat = DAT_O; ack = ACK_O; err = ERR_O;
    tick();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
  endtask

  function automatic logic [31:0] status_exp();
    return {24'b0, 4'(sbq.size()), 1'b0, exp_ovr, exp_ferr, sbq.size() == 0};
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] d; logic a, e; logic [31:0] want;
    want = status_exp();
    wb_cycle(1'b0, 2'd1, '0, d, a, e);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
    check({tag, "_stat"}, d, want);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d; logic a, e;
    wb_cycle(1'b0, 2'd0, '0, d, a, e);
    if (sbq.size() > 0) begin
      check({tag, "_ack"}, {31'b0, a}, 32'd1);
      check({tag, "_err"}, {31'b0, e}, 32'd0);
      check({tag, "_dat"}, d, {5'b0, sbq.pop_front()});
    end else begin
      check({tag, "_ack"}, {31'b0, a}, 32'd0);
      check({tag, "_err"}, {31'b0, e}, 32'd1);
      check({tag, "_dat"}, d, 32'd0);
    end
  endtask

  task automatic write_status(input string tag, input logic [31:0] v);
    logic [31:0] d; logic a, e;
    wb_cycle(1'b1, 2'd1, v, d, a, e);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
  endtask

  initial begin
    logic [26:0] f1;
    logic [26:0] junk;
    logic [31:0] d; logic a, e;

    // Reset state
    tick(); tick();
    check("rst_valid", {31'b0, rx_valid_o}, 32'd0);
    check("rst_ack", {31'b0, ACK_O}, 32'd0);
    check("rst_err", {31'b0, ERR_O}, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    rst_ni = 1'b1; tick();
    check_status("rst");

    // Single frame and its latency
    f1 = {1'b1, 8'hAB, 1'b0, 8'hCD, 1'b1, 8'hEF};
    send_frame(f1, 1'b1);
    tick();
    check("lat_early", {31'b0, rx_valid_o}, 32'd0);
    tick();
    check("lat_31", {31'b0, rx_valid_o}, 32'd1);
    sb_push(f1);
    read_data("t1");
    check("t1_drained", {31'b0, rx_valid_o}, 32'd0);
    check("idle_ack", {31'b0, ACK_O}, 32'd0);

    // Back-to-back frames into a 4-deep FIFO -> overrun
    for (int i = 1; i <= 5; i++) begin
      send_frame(27'(i), 1'b1);
      sb_push(27'(i));
    end
    tick(); tick(); tick();
    check_status("t2");
    for (int i = 0; i < 5; i++) read_data("t2_rd");
    write_status("t2_clr", 32'h4);
    exp_ovr = 1'b0;
    check_status("t2_after");

    // Bad stop bit, stuck-low line, then a good frame
    send_frame(27'h1234567, 1'b0);
    data_i = 1'b0;
    repeat (10) tick();
    check("t3_nopush", {31'b0, rx_valid_o}, 32'd0);
    data_i = 1'b1;
    repeat (4) tick();
    exp_ferr = 1'b1;
    check_status("t3_ferr");
    send_frame(27'h2AAAAAA, 1'b1);
    sb_push(27'h2AAAAAA);
    tick(); tick();
    read_data("t3_rd");
    write_status("t3_clr", 32'h2);
    exp_ferr = 1'b0;
    check_status("t3_after");

    // Error responses
    read_data("t4_empty");
    wb_cycle(1'b1, 2'd0, 32'h123, d, a, e);
    check("t4_wdata_ack", {31'b0, a}, 32'd0);
    check("t4_wdata_err", {31'b0, e}, 32'd1);
    wb_cycle(1'b0, 2'd2, '0, d, a, e);
    check("t4_badadr_err", {31'b0, e}, 32'd1);
    check("t4_badadr_dat", d, 32'd0);
    check_status("t4_unchanged");

    // Full FIFO: pop lands on the same edge as the STOP push
    for (int i = 0; i < 4; i++) begin
      send_frame(27'h10 + 27'(i), 1'b1);
      sb_push(27'h10 + 27'(i));
    end
    tick(); tick();
    check_status("t5_full");
    send_frame(27'h14, 1'b1);
    tick();
    read_data("t5_race");
    sbq.push_back(27'h14);
    check_status("t5_level");
    for (int i = 0; i < 4; i++) read_data("t5_drain");

    // Reset mid-frame
    junk = 27'h5A5A5A5;
    data_i = 1'b0; tick();
    for (int i = 26; i > 13; i--) begin
      data_i = junk[i]; tick();
    end
    rst_ni = 1'b0; data_i = 1'b1;
    tick(); tick();
    check("t6_rst_valid", {31'b0, rx_valid_o}, 32'd0);
    rst_ni = 1'b1;
    tick(); tick();
    sbq.delete();
    exp_ovr = 1'b0; exp_ferr = 1'b0;
    send_frame(27'h0000055, 1'b1);
    sb_push(27'h0000055);
    tick(); tick();
    check_status("t6_one");
    read_data("t6_rd");
    check_status("t6_final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
